// File: rtl/bar_level_meter.sv
// rtl/bar_level_meter.sv - four-channel peak-hold audio bar level meter
//
// Purpose: tracks the peak magnitude of a time-multiplexed stream of signed
// 8-bit samples per channel, and once per hline strobe turns those peaks into
// 4-bit bar levels with a peak hold followed by a linear decay.
//
// Ports:
//   clock         in   pixel clock
//   reset         in   asynchronous, active-high
//   ena           in   clock enable; all state frozen when low
//   sample_valid  in   sample/sample_ch valid this cycle
//   sample_ch     in   [1:0] channel index (0 -> s1 ... 3 -> s4)
//   sample        in   [7:0] signed two's-complement sample
//   hline         in   level-update strobe (1-cycle pulse)
//   s1..s4        out  [3:0] displayed bar level per channel
//   clip          out  [3:0] per-channel clip flag, bit n = channel n

module bar_level_meter #(
  parameter int HOLD_TICKS = 60,
  parameter int DECAY_DIV  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       sample_valid,
  input  logic [1:0] sample_ch,
  input  logic [7:0] sample,
  input  logic       hline,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] s3,
  output logic [3:0] s4,
  output logic [3:0] clip
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);
  localparam logic [7:0] DIV_LAST  = 8'(DECAY_DIV - 1);

  logic [3:0] level_q [4];
  logic [3:0] level_d [4];
  logic [3:0] acc_q   [4];
  logic [3:0] acc_d   [4];
  logic [7:0] hold_q  [4];
  logic [7:0] hold_d  [4];
  logic [7:0] div_q, div_d;
  logic [3:0] clip_q, clip_d;

  logic [7:0] neg_sample;
  logic [7:0] abs_val;
  logic [3:0] mag;
  logic       clip_hit;
  logic       do_update;
  logic       do_sample;
  logic       dtick;

  // -128 has no positive 8-bit counterpart, so it saturates to 127.
  assign neg_sample = 8'(~sample + 8'd1);
  assign abs_val    = (sample == 8'h80) ? 8'd127 :
                      (sample[7] ? neg_sample : sample);
  assign mag        = abs_val[6:3];
  assign clip_hit   = (abs_val >= 8'd127);

  assign do_update  = ena & hline;
  assign do_sample  = ena & sample_valid;
  assign dtick      = (div_q == DIV_LAST);

  always_comb begin
    level_d = level_q;
    acc_d   = acc_q;
    hold_d  = hold_q;
    div_d   = div_q;
    clip_d  = clip_q;

    if (do_update) begin
      div_d = dtick ? 8'd0 : 8'(div_q + 8'd1);
      for (int n = 0; n < 4; n++) begin
        // An equal nonzero peak re-arms the hold; an empty interval never does.
        if ((acc_q[n] >= level_q[n]) && (acc_q[n] != 4'd0)) begin
          level_d[n] = acc_q[n];
          hold_d[n]  = HOLD_INIT;
        end else if (hold_q[n] != 8'd0) begin
          hold_d[n]  = 8'(hold_q[n] - 8'd1);
        end else if (dtick && (level_q[n] != 4'd0)) begin
          level_d[n] = 4'(level_q[n] - 4'd1);
        end
        acc_d[n] = 4'd0;
      end
      clip_d = 4'd0;
    end

    // Applied after the hline clear so a coincident sample lands in the
    // next interval instead of being dropped.
    if (do_sample) begin
      if (mag > acc_d[sample_ch]) begin
        acc_d[sample_ch] = mag;
      end
      clip_d[sample_ch] = clip_d[sample_ch] | clip_hit;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        level_q[n] <= 4'd0;
        acc_q[n]   <= 4'd0;
        hold_q[n]  <= 8'd0;
      end
      div_q  <= 8'd0;
      clip_q <= 4'd0;
    end else begin
      level_q <= level_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      clip_q  <= clip_d;
    end
  end

  assign s1   = level_q[0];
  assign s2   = level_q[1];
  assign s3   = level_q[2];
  assign s4   = level_q[3];
  assign clip = clip_q;

endmodule

// File: tb/tb_bar_level_meter.sv
// tb/tb_bar_level_meter.sv - self-checking bench for bar_level_meter
//
// Purpose: drives directed and randomized sample/hline traffic and compares
// the bar levels and clip flags against a behavioural model of the meter.
// Ports: none (top-level bench).

module tb_bar_level_meter;

  localparam int HOLD = 60;
  localparam int DDIV = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       sample_valid = 1'b0;
  logic [1:0] sample_ch = 2'd0;
  logic [7:0] sample = 8'd0;
  logic       hline = 1'b0;
  logic [3:0] s1, s2, s3, s4, clip;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_level [4];
  int m_hold  [4];
  int m_peak  [4];
  bit m_clip  [4];
  int m_hcount;

  bar_level_meter #(.HOLD_TICKS(HOLD), .DECAY_DIV(DDIV)) dut (
    .clock(clock), .reset(reset), .ena(ena), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample(sample), .hline(hline),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .clip(clip)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] exp_levels();
    return {4'(m_level[3]), 4'(m_level[2]), 4'(m_level[1]), 4'(m_level[0])};
  endfunction

  function automatic logic [3:0] exp_clip();
    return {m_clip[3], m_clip[2], m_clip[1], m_clip[0]};
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_level[n] = 0; m_hold[n] = 0; m_peak[n] = 0; m_clip[n] = 0;
    end
    m_hcount = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int ch,
                            input logic [7:0] smp, input bit hl);
    int  a;
    bit  decay_now;
    if (!en) return;
    if (hl) begin
      // Every DECAY_DIV-th enabled hline since reset is a decay opportunity.
      decay_now = (m_hcount % DDIV) == (DDIV - 1);
      m_hcount++;
      for (int n = 0; n < 4; n++) begin
        if (m_peak[n] > 0 && m_peak[n] >= m_level[n]) begin
          m_level[n] = m_peak[n];
          m_hold[n]  = HOLD;
        end else if (m_hold[n] > 0) begin
          m_hold[n]--;
        end else if (decay_now && m_level[n] > 0) begin
          m_level[n]--;
        end
        m_peak[n] = 0;
        m_clip[n] = 0;
      end
    end
    if (v) begin
      a = int'($signed(smp));
      if (a < 0) a = -a;
      if (a > 127) a = 127;
      if (a / 8 > m_peak[ch]) m_peak[ch] = a / 8;
      if (a >= 127) m_clip[ch] = 1;
    end
  endtask

  task automatic drive(input bit en, input bit v, input logic [1:0] ch,
                       input logic [7:0] smp, input bit hl);
    ena = en; sample_valid = v; sample_ch = ch; sample = smp; hline = hl;
    @(posedge clock);
    #1;
    ena = 1'b1; sample_valid = 1'b0; hline = 1'b0;
    model_step(en, v, int'(ch), smp, hl);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    ena = 1'b1; sample_valid = 1'b0; hline = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({s4, s3, s2, s1} !== 16'h0) begin
      n_fail++; $display("FAIL reset_levels: got %h expected 0000", {s4, s3, s2, s1});
    end
    n_tests++;
    if (clip !== 4'h0) begin
      n_fail++; $display("FAIL reset_clip: got %h expected 0", clip);
    end
  endtask

  task automatic test_peak_hold_decay();
    do_reset();
    drive(1, 1, 2'd0, 8'h40, 0);
    drive(1, 0, 2'd0, 8'h00, 1);
    n_tests++;
    if ({s4, s3, s2, s1} !== 16'h0008) begin
      n_fail++; $display("FAIL peak_capture: got %h expected 0008", {s4, s3, s2, s1});
    end
    for (int i = 0; i < 60; i++) begin
      drive(1, 0, 2'd0, 8'h00, 1);
      n_tests++;
      if (s1 !== 4'd8) begin
        n_fail++; $display("FAIL hold_%0d: got %0d expected 8", i, s1);
      end
    end
    for (int i = 0; i < 200; i++) begin
      drive(1, 0, 2'd0, 8'h00, 1);
      n_tests++;
      if ({s4, s3, s2, s1} !== exp_levels()) begin
        n_fail++;
        $display("FAIL decay_%0d: got %h expected %h", i, {s4, s3, s2, s1}, exp_levels());
      end
    end
    n_tests++;
    if (s1 !== 4'd0) begin
      n_fail++; $display("FAIL decay_floor: got %0d expected 0", s1);
    end
  endtask

  task automatic test_clip();
    do_reset();
    drive(1, 1, 2'd2, 8'h80, 0);
    n_tests++;
    if (clip !== 4'b0100) begin
      n_fail++; $display("FAIL clip_set: got %b expected 0100", clip);
    end
    drive(1, 0, 2'd0, 8'h00, 1);
    n_tests++;
    if (s3 !== 4'd15) begin
      n_fail++; $display("FAIL clip_level: got %0d expected 15", s3);
    end
    n_tests++;
    if (clip !== 4'b0000) begin
      n_fail++; $display("FAIL clip_clear: got %b expected 0000", clip);
    end
  endtask

  task automatic test_interval_max();
    do_reset();
    drive(1, 1, 2'd1, 8'h10, 0);
    drive(1, 1, 2'd1, 8'hE0, 0);
    drive(1, 1, 2'd1, 8'h08, 0);
    drive(1, 0, 2'd0, 8'h00, 1);
    n_tests++;
    if ({s4, s3, s2, s1} !== 16'h0040) begin
      n_fail++; $display("FAIL interval_max: got %h expected 0040", {s4, s3, s2, s1});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 2'd3, 8'h7F, 1);
    n_tests++;
    if (s4 !== 4'd0) begin
      n_fail++; $display("FAIL b2b_same_hline: got %0d expected 0", s4);
    end
    n_tests++;
    if (clip !== 4'b1000) begin
      n_fail++; $display("FAIL b2b_clip: got %b expected 1000", clip);
    end
    drive(1, 0, 2'd0, 8'h00, 1);
    n_tests++;
    if (s4 !== 4'd15) begin
      n_fail++; $display("FAIL b2b_next_hline: got %0d expected 15", s4);
    end
  endtask

  task automatic test_enable();
    logic [15:0] frozen;
    do_reset();
    drive(1, 1, 2'd0, 8'h40, 0);
    drive(1, 0, 2'd0, 8'h00, 1);
    for (int i = 0; i < 10; i++) drive(1, 0, 2'd0, 8'h00, 1);
    frozen = {s4, s3, s2, s1};
    for (int i = 0; i < 50; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            (i % 5 == 0) ? 8'h80 : 8'($urandom), 1'($urandom_range(0, 1)));
      n_tests++;
      if ({clip, s4, s3, s2, s1} !== {4'b0000, 16'h0008}) begin
        n_fail++;
        $display("FAIL ena_frozen_%0d: got %h expected %h", i, {clip, s4, s3, s2, s1}, {4'b0000, frozen});
      end
    end
    for (int i = 0; i < 150; i++) begin
      drive(1, 0, 2'd0, 8'h00, 1);
      n_tests++;
      if ({s4, s3, s2, s1} !== exp_levels()) begin
        n_fail++;
        $display("FAIL ena_resume_%0d: got %h expected %h", i, {s4, s3, s2, s1}, exp_levels());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 1, 2'd0, 8'h7F, 0);
    drive(1, 1, 2'd1, 8'h40, 0);
    drive(1, 1, 2'd2, 8'h80, 0);
    drive(1, 0, 2'd0, 8'h00, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 2'd0, 8'h00, 1);
    drive(1, 1, 2'd3, 8'h80, 0);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({clip, s4, s3, s2, s1} !== 20'h0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 00000", {clip, s4, s3, s2, s1});
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    drive(1, 0, 2'd0, 8'h00, 1);
    n_tests++;
    if ({clip, s4, s3, s2, s1} !== 20'h0) begin
      n_fail++; $display("FAIL post_reset_hline: got %h expected 00000", {clip, s4, s3, s2, s1});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
      n_tests++;
      if ({clip, s4, s3, s2, s1} !== {exp_clip(), exp_levels()}) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", i, {clip, s4, s3, s2, s1}, {exp_clip(), exp_levels()});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_peak_hold_decay();
    test_clip();
    test_interval_max();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
